gcd_initiator: RTL

Self-test initiator for the GCD core: on a start pulse it steps through a fixed table of eight operand pairs, drives each pair onto the core's operand inputs, issues a one-cycle go, and waits for the core's done. It then checks the returned GCD against the expected value and keeps pass/fail tallies. It sits in the 25 MHz domain between the debounced/pulsed start button and the GCD core, replacing the switch-driven operand path during board bring-up.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_vec_rom.sv | 15 +
 rtl/gcd_initiator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD self-test initiator: FSM states, sizes and the
// fixed operand/expected-result table.
package gcd_pkg;
    localparam int WIDTH   = 4;
    localparam int NUM_VEC = 8;
    localparam int IDX_W   = $clog2(NUM_VEC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] VEC_X [NUM_VEC] = '{4'd12, 4'd15, 4'd9, 4'd7, 4'd10, 4'd14, 4'd15, 4'd13};
    localparam logic [WIDTH-1:0] VEC_Y [NUM_VEC] = '{4'd8,  4'd5,  4'd6, 4'd3, 4'd10, 4'd4,  4'd15, 4'd11};
    localparam logic [WIDTH-1:0] VEC_E [NUM_VEC] = '{4'd4,  4'd5,  4'd3, 4'd1, 4'd10, 4'd2,  4'd15, 4'd1};
endpackage

// File: rtl/gcd_vec_rom.sv
// Combinational vector table: index -> operands and expected GCD.
module gcd_vec_rom
    import gcd_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] expected
);
    always_comb begin
        x        = VEC_X[idx];
        y        = VEC_Y[idx];
        expected = VEC_E[idx];
    end
endmodule

// File: rtl/gcd_initiator.sv
// Self-test initiator: walks the vector table through the GCD core, one go per
// vector, and tallies matches, mismatches and timeouts. All outputs registered.
module gcd_initiator
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             go_o,
    input  logic             done_i,
    input  logic [WIDTH-1:0] gcd_i,
    output logic [WIDTH-1:0] result_o,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             finished,
    output logic [3:0]       pass_cnt,
    output logic [3:0]       fail_cnt,
    output logic             timeout
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q;
    logic             vec_tmo_q;
    logic [WIDTH-1:0] exp_q;
    logic [IDX_W-1:0] rom_idx;
    logic [WIDTH-1:0] rom_x, rom_y, rom_e;

    // Only two places load operands: run start (vector 0) and CHECK (next vector).
    assign rom_idx = (state_q == S_CHECK) ? vec_idx + 3'd1 : '0;

    gcd_vec_rom u_rom (
        .idx      (rom_idx),
        .x        (rom_x),
        .y        (rom_y),
        .expected (rom_e)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_ISSUE;
            S_ISSUE:        state_d = S_WAIT;
            S_WAIT:         if (done_i || cnt_q == TMO) state_d = S_CHECK;
            S_CHECK:        state_d = (vec_idx == IDX_W'(NUM_VEC - 1)) ? S_DONE : S_ISSUE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vec_tmo_q <= 1'b0;
            exp_q     <= '0;
            x_o       <= '0;
            y_o       <= '0;
            go_o      <= 1'b0;
            result_o  <= '0;
            vec_idx   <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_o    <= (state_d == S_ISSUE);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_cnt <= '0;
                        fail_cnt <= '0;
                        timeout  <= 1'b0;
                        result_o <= '0;
                        finished <= 1'b0;
                        vec_idx  <= '0;
                        busy     <= 1'b1;
                        x_o      <= rom_x;
                        y_o      <= rom_y;
                        exp_q    <= rom_e;
                    end
                end
                S_ISSUE: begin
                    cnt_q     <= '0;
                    vec_tmo_q <= 1'b0;
                end
                S_WAIT: begin
                    // A response landing on the timeout cycle still counts as a response.
                    if (done_i) begin
                        result_o <= gcd_i;
                    end else if (cnt_q == TMO) begin
                        timeout   <= 1'b1;
                        vec_tmo_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (!vec_tmo_q && result_o == exp_q) pass_cnt <= pass_cnt + 4'd1;
                    else                                 fail_cnt <= fail_cnt + 4'd1;
                    if (vec_idx == IDX_W'(NUM_VEC - 1)) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        vec_idx <= vec_idx + 3'd1;
                        x_o     <= rom_x;
                        y_o     <= rom_y;
                        exp_q   <= rom_e;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
